// File: rtl/reg_write_arbiter_pkg.sv
// Shared types for the register-file write arbiter: basic register/data
// types plus the pipeline write-request struct and the grant encoding.
package reg_write_arbiter_pkg;

    // Basic types
    typedef logic [4:0]  RegAddr;
    typedef logic [31:0] BasicData;

    // Pipeline types
    typedef struct packed {
        logic     valid;
        RegAddr   addr;
        BasicData data;
    } wreq_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_A    = 2'd1,
        GRANT_B    = 2'd2
    } grant_e;

endpackage

// File: rtl/reg_write_arb_grant.sv
// Combinational grant decision for the two write requesters. The caller
// chooses the tie-break through prefer_b: the starvation flag in fixed
// priority mode, the round-robin pointer otherwise.
module reg_write_arb_grant
    import reg_write_arbiter_pkg::*;
(
    input  logic   a_valid,
    input  logic   b_valid,
    input  logic   prefer_b,
    output grant_e grant
);

    // Lone requesters win outright; a tie goes to whoever prefer_b names
    always_comb begin
        grant = GRANT_NONE;
        if (a_valid && b_valid) begin
            grant = prefer_b ? GRANT_B : GRANT_A;
        end else if (a_valid) begin
            grant = GRANT_A;
        end else if (b_valid) begin
            grant = GRANT_B;
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Register-file write-port arbiter between the writeback stage (A) and a
// long-latency unit (B). One granted write per cycle is registered onto the
// register-file port. Writes to register 0 are accepted but never strobed.
// Build option REG_WRITE_ARB_ROUND_ROBIN_EN: alternate ties between A and B
// instead of fixed A priority with a starvation limit.
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       aValid,
    input  RegAddr     aAddr,
    input  BasicData   aData,
    output logic       aReady,
    input  logic       bValid,
    input  RegAddr     bAddr,
    input  BasicData   bData,
    output logic       bReady,
    output logic       wEnable,
    output RegAddr     wAddr,
    output BasicData   wData,
    output logic [3:0] starveCnt
);

    wreq_t      a_req;
    wreq_t      b_req;
    wreq_t      wr_q;
    grant_e     grant;
    logic       prefer_b;
    logic [3:0] starve_q;

    // Requests are masked during reset so nothing is granted while rst is high
    assign a_req = '{valid: aValid & ~rst, addr: aAddr, data: aData};
    assign b_req = '{valid: bValid & ~rst, addr: bAddr, data: bData};

    reg_write_arb_grant u_grant (
        .a_valid  (a_req.valid),
        .b_valid  (b_req.valid),
        .prefer_b (prefer_b),
        .grant    (grant)
    );

    assign aReady = (grant == GRANT_A);
    assign bReady = (grant == GRANT_B);

`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
    logic ptr_q;  // 1: B is preferred on the next tie

    assign prefer_b = ptr_q;
    assign starve_q = 4'd0;

    // Prefer the requester that was not granted most recently
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= 1'b0;
        end else if (grant == GRANT_A) begin
            ptr_q <= 1'b1;
        end else if (grant == GRANT_B) begin
            ptr_q <= 1'b0;
        end
    end
`else
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    assign prefer_b = (starve_q == LIMIT);

    // Count A grants that made a waiting B lose; any B grant or idle B clears
    always_ff @(posedge clk) begin
        if (rst || grant == GRANT_B || !bValid) begin
            starve_q <= 4'd0;
        end else if (grant == GRANT_A && starve_q != LIMIT) begin
            starve_q <= starve_q + 4'd1;
        end
    end
`endif

    // Register the granted write; an idle cycle drops the strobe and holds addr/data
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
        end else begin
            case (grant)
                GRANT_A: wr_q <= '{valid: (a_req.addr != '0), addr: a_req.addr, data: a_req.data};
                GRANT_B: wr_q <= '{valid: (b_req.addr != '0), addr: b_req.addr, data: b_req.data};
                default: wr_q.valid <= 1'b0;
            endcase
        end
    end

    // Masking with rst kills a write still in flight when reset arrives
    assign wEnable   = wr_q.valid & ~rst;
    assign wAddr     = rst ? '0 : wr_q.addr;
    assign wData     = rst ? '0 : wr_q.data;
    assign starveCnt = rst ? 4'd0 : starve_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter. Inputs change 1 ns after the rising
// edge; ready outputs are sampled 1 ns later, registered outputs 1 ns after
// the next rising edge.
module tb_reg_write_arbiter;
    import reg_write_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       aValid, bValid;
    RegAddr     aAddr, bAddr;
    BasicData   aData, bData;
    logic       aReady, bReady, wEnable;
    RegAddr     wAddr;
    BasicData   wData;
    logic [3:0] starveCnt;

    int passed = 0;
    int total  = 0;

`ifdef REG_WRITE_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    reg_write_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .aValid    (aValid),
        .aAddr     (aAddr),
        .aData     (aData),
        .aReady    (aReady),
        .bValid    (bValid),
        .bAddr     (bAddr),
        .bData     (bData),
        .bReady    (bReady),
        .wEnable   (wEnable),
        .wAddr     (wAddr),
        .wData     (wData),
        .starveCnt (starveCnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance to 1 ns after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        aValid = 1'b1; aAddr = 5'd3; aData = 32'h1234;
        bValid = 1'b1; bAddr = 5'd4; bData = 32'h5678;
        #1;
        tick();
        #1;
        // Reset state with both requests pending
        chk("rst_aReady", aReady, 0);
        chk("rst_bReady", bReady, 0);
        chk("rst_wEnable", wEnable, 0);
        chk("rst_wAddr", wAddr, 0);
        chk("rst_wData", wData, 0);
        chk("rst_starve", starveCnt, 0);
        tick();
        rst = 1'b0;

        // A only
        aValid = 1'b1; aAddr = 5'd5; aData = 32'h11; bValid = 1'b0;
        #1;
        chk("aonly_aReady", aReady, 1);
        chk("aonly_bReady", bReady, 0);
        tick();
        chk("aonly_wEnable", wEnable, 1);
        chk("aonly_wAddr", wAddr, 5);
        chk("aonly_wData", wData, 32'h11);
        aValid = 1'b0;
        #1;
        chk("idle_aReady", aReady, 0);
        tick();
        chk("idle_wEnable", wEnable, 0);
        chk("idle_wAddr_hold", wAddr, 5);
        chk("idle_wData_hold", wData, 32'h11);

        // Contention: starvation limit or round-robin alternation
        do_reset();
        aValid = 1'b1; aAddr = 5'd1; aData = 32'hA0;
        bValid = 1'b1; bAddr = 5'd2; bData = 32'hB0;
        for (int i = 0; i < (RR ? 4 : 5); i++) begin
            bit exp_b;
            exp_b = RR ? (i % 2 == 1) : (i == 4);
            #1;
            chk($sformatf("cont%0d_aReady", i), aReady, !exp_b);
            chk($sformatf("cont%0d_bReady", i), bReady, exp_b);
            tick();
            chk($sformatf("cont%0d_wAddr", i), wAddr, exp_b ? 2 : 1);
            chk($sformatf("cont%0d_wData", i), wData, exp_b ? 32'hB0 : 32'hA0);
            chk($sformatf("cont%0d_starve", i), starveCnt, RR ? 0 : (i < 4 ? i + 1 : 0));
        end
        aValid = 1'b0; bValid = 1'b0;
        tick();
        chk("cont_idle_starve", starveCnt, 0);

        // Same address: A then B, B is the final value of register 7
        do_reset();
        aValid = 1'b1; aAddr = 5'd7; aData = 32'hAA;
        bValid = 1'b1; bAddr = 5'd7; bData = 32'hBB;
        #1;
        chk("same_aReady", aReady, 1);
        tick();
        chk("same_w1_en", wEnable, 1);
        chk("same_w1_data", wData, 32'hAA);
        aValid = 1'b0;
        #1;
        chk("same_bReady", bReady, 1);
        tick();
        chk("same_w2_en", wEnable, 1);
        chk("same_w2_addr", wAddr, 7);
        chk("same_w2_data", wData, 32'hBB);
        bValid = 1'b0;
        tick();

        // Register 0 write is accepted but not strobed
        bValid = 1'b1; bAddr = 5'd0; bData = 32'hFF;
        #1;
        chk("x0_bReady", bReady, 1);
        tick();
        chk("x0_wEnable", wEnable, 0);
        bValid = 1'b0;
        tick();

        // Reset right after a transfer kills the write; held B wins after reset
        aValid = 1'b1; aAddr = 5'd3; aData = 32'h33;
        #1;
        chk("rmid_aReady", aReady, 1);
        tick();
        rst = 1'b1; aValid = 1'b0;
        bValid = 1'b1; bAddr = 5'd9; bData = 32'h99;
        #1;
        chk("rmid_wEnable", wEnable, 0);
        chk("rmid_bReady_in_rst", bReady, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("rmid_bReady_after", bReady, 1);
        tick();
        chk("rmid_w_en", wEnable, 1);
        chk("rmid_w_addr", wAddr, 9);
        chk("rmid_w_data", wData, 32'h99);
        bValid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: max consecutive A grants while B waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 aValid  input  1  writeback-stage write request.
REQ-005 aAddr  input  RegAddr  A destination register.
REQ-006 aData  input  BasicData  A write data.
REQ-007 aReady  output  1  A granted this cycle; combinational.
REQ-008 bValid  input  1  long-latency-unit write request.
REQ-009 bAddr  input  RegAddr  B destination register.
REQ-010 bData  input  BasicData  B write data.
REQ-011 bReady  output  1  B granted this cycle; combinational.
REQ-012 wEnable  output  1  register file write strobe; registered.
REQ-013 wAddr  output  RegAddr  register file write address; registered.
REQ-014 wData  output  BasicData  register file write data; registered.
REQ-015 starveCnt  output  4  current consecutive-A-grant-while-B-waits count; debug.

Function
- REQ-016 Handshake: a transfer on a requester occurs in a cycle where valid and ready are both 1; valid never depends on ready; once asserted, valid, addr and data hold until transfer.
- REQ-017 At most one of aReady/bReady is 1 per cycle; a ready is 1 only when its valid is 1.
- REQ-018 Only A valid -> grant A; only B valid -> grant B; neither valid -> no grant.
- REQ-019 Both valid, default priority: grant A, unless starveCnt == STARVE_LIMIT, in which case grant B.
- REQ-020 starveCnt: increments by 1 on a cycle with A granted and bValid=1; clears to 0 on any B grant or any cycle with bValid=0; saturates at STARVE_LIMIT.
- REQ-021 Latency: a transfer in cycle N produces wEnable=1, wAddr, wData of the granted request in cycle N+1; no grant in N -> wEnable=0 in N+1, wAddr/wData hold.
- REQ-022 Writes to register 0: transfer completes normally; wEnable=0 in N+1.
- REQ-023 Both valid with equal addresses: writes land in grant order; the later grant is the final register value.
- REQ-024 Throughput: one write per cycle sustained; no bubble between back-to-back grants.

Reset
- REQ-025 While rst=1: aReady=0, bReady=0, wEnable=0, wAddr=0, wData=0, starveCnt=0, priority pointer=A.
- REQ-026 Requests present during reset are not granted; an untransferred request is re-arbitrated from reset state in the first cycle after rst falls.
- REQ-027 rst asserted in cycle N+1 after a transfer in cycle N suppresses that write (wEnable=0).

Configuration
- REQ-028 Macro REG_WRITE_ARB_ROUND_ROBIN_EN defined: when both valid, grant the requester not granted most recently (pointer toggles on every grant), starting from A after reset; starveCnt held at 0 and STARVE_LIMIT ignored.
- REQ-029 Macro undefined: fixed A priority with the starvation limit per REQ-019/REQ-020.

Structure
- REQ-030 RegAddr and BasicData come from the shared basic-types package; the write-request struct {valid, addr, data} and the grant encoding enum {GRANT_NONE, GRANT_A, GRANT_B} go in the shared pipeline-types package.
- REQ-031 The grant decision lives in one combinational sub-module reg_write_arb_grant; the top holds starveCnt, pointer and the output registers.

Verification
- REQ-032 A only: aValid=1, aAddr=5, aData=0x11 for 1 cycle -> aReady=1 same cycle; next cycle wEnable=1, wAddr=5, wData=0x11.
- REQ-033 Starvation: STARVE_LIMIT=4, A and B valid continuously -> 4 A grants, 5th grant to B, starveCnt sequence 1,2,3,4,0.
- REQ-034 Same address: A(addr 7, 0xAA) and B(addr 7, 0xBB) valid together -> A written in cycle N+1, B in N+2; register 7 ends at 0xBB.
- REQ-035 x0: bValid=1, bAddr=0, bData=0xFF -> bReady=1; next cycle wEnable=0.
- REQ-036 Reset mid-operation: transfer in cycle N, rst=1 in N+1 -> wEnable=0 in N+1; a B request held through reset is granted in the first cycle after rst falls.
- REQ-037 With REG_WRITE_ARB_ROUND_ROBIN_EN: A and B valid for 4 cycles -> grants A,B,A,B; starveCnt stays 0.
